fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage that feeds the ID/EX register. It owns the 22-bit PC, drives a synchronous-read instruction memory, applies hazard stalls and EX-resolved branch redirects, and detects HLT. HLT detection produces the sticky `hlt` signal used by the downstream pipeline registers.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_ctrl.sv | 56 +++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the fetch stage and its neighbours:
//                opcode field position, HLT opcode, fetch FSM states and the
//                default PC/instruction widths.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int PC_W_DEF    = 22;
  localparam int INSTR_W_DEF = 32;

  // Opcode field position inside an instruction word
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [OP_MSB-OP_LSB:0] HLT_OP = 5'b11111;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,   // memory pipeline holds no real data yet
    ST_RUN  = 2'd1,   // steady-state fetching
    ST_HALT = 2'd2    // HLT seen; frozen until reset
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch-stage FSM. Produces advance / redirect / drain /
//                halt-set decodes consumed by the fetch datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic branch_taken_i,
  input  logic f_valid_i,
  input  logic hlt_op_i,
  output logic advance_o,
  output logic redirect_o,
  output logic drain_o,
  output logic halt_set_o,
  output logic halted_o
);

  fetch_state_e state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Decodes and next state; a branch outranks both stall and HLT detection
  always_comb begin
    logic halted;
    logic redirect;
    logic advance;
    logic halt_set;
    halted   = (state_q == ST_HALT);
    redirect = branch_taken_i && !halted;
    advance  = !halted && !branch_taken_i && !stall_i;
    halt_set = advance && (state_q == ST_RUN) && f_valid_i && hlt_op_i;

    state_d = state_q;
    if (redirect)                            state_d = ST_FILL;
    else if (halt_set)                       state_d = ST_HALT;
    else if (advance && state_q == ST_FILL)  state_d = ST_RUN;

    halted_o   = halted;
    redirect_o = redirect;
    advance_o  = advance;
    halt_set_o = halt_set;
    drain_o    = halted && !stall_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with IF/ID register. Owns the PC, drives a
//                1-cycle synchronous instruction memory, handles stalls,
//                EX branch redirects and sticky HLT detection.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_rd_data,
  output logic [PC_W-1:0]    instr_addr,
  output logic [PC_W-1:0]    ID_PC,
  output logic [PC_W-1:0]    ID_PC_out,
  output logic [INSTR_W-1:0] ID_instr,
  output logic               ID_valid,
  output logic               hlt
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_f_q, pc_f_d;
  logic               f_valid_q, f_valid_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic               hlt_q, hlt_d;

  logic advance, redirect, drain, halt_set, halted;
  logic instr_is_hlt;

  assign instr_is_hlt = (instr_rd_data[OP_MSB:OP_LSB] == HLT_OP);

  fetch_ctrl u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .f_valid_i      (f_valid_q),
    .hlt_op_i       (instr_is_hlt),
    .advance_o      (advance),
    .redirect_o     (redirect),
    .drain_o        (drain),
    .halt_set_o     (halt_set),
    .halted_o       (halted)
  );

  // Re-present pc_f while holding so read data keeps matching pc_f
  assign instr_addr = (stall || halted) ? pc_f_q : pc_q;

  assign ID_PC     = id_pc_q;
  assign ID_PC_out = id_pc_q + PC_W'(1);
  assign ID_instr  = id_instr_q;
  assign ID_valid  = id_valid_q;
  assign hlt       = hlt_q;

  // Next-state datapath: redirect flushes, advance shifts, drain bubbles ID
  always_comb begin
    pc_d       = pc_q;
    pc_f_d     = pc_f_q;
    f_valid_d  = f_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    hlt_d      = hlt_q;
    if (redirect) begin
      pc_d       = branch_target;
      f_valid_d  = 1'b0;
      id_valid_d = 1'b0;
    end else if (advance) begin
      id_instr_d = instr_rd_data;
      id_pc_d    = pc_f_q;
      id_valid_d = f_valid_q;
      pc_f_d     = pc_q;
      f_valid_d  = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      if (halt_set) hlt_d = 1'b1;
    end else if (drain) begin
      id_valid_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_f_q     <= '0;
      f_valid_q  <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_f_q     <= pc_f_d;
      f_valid_q  <= f_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      hlt_q      <= hlt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A program-order
//                reference model pushes the expected IF/ID view for every
//                clock edge; a monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam int PC_W    = 22;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stall = 1'b0;
  logic               branch_taken = 1'b0;
  logic [PC_W-1:0]    branch_target = '0;
  logic [INSTR_W-1:0] instr_rd_data = '0;
  logic [PC_W-1:0]    instr_addr, ID_PC, ID_PC_out;
  logic [INSTR_W-1:0] ID_instr;
  logic               ID_valid, hlt;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_rd_data (instr_rd_data),
    .instr_addr    (instr_addr),
    .ID_PC         (ID_PC),
    .ID_PC_out     (ID_PC_out),
    .ID_instr      (ID_instr),
    .ID_valid      (ID_valid),
    .hlt           (hlt)
  );

  always #5 clk = ~clk;

  // Program image: HLT words where requested, otherwise 0x1000_0000 + address
  bit hlt_at [logic [PC_W-1:0]];

  function automatic logic [INSTR_W-1:0] mem(input logic [PC_W-1:0] a);
    if (hlt_at.exists(a)) return 32'hF800_0000;
    return 32'h1000_0000 + {10'b0, a};
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) instr_rd_data <= mem(instr_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  typedef struct {
    bit              rst;
    bit              valid;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    bit              hlt;
    bit              halted;
    logic [PC_W-1:0] haddr;
  } exp_t;

  exp_t q[$];

  // Reference model in program order: which instruction ID should show
  logic [PC_W-1:0] m_next = '0;   // next program address to deliver
  int              m_skip = 1;    // bubbles still owed before delivery resumes
  bit              m_halted = 0;
  exp_t            m_cur;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_next   = '0;
      m_skip   = 1;
      m_halted = 0;
      m_cur    = '{rst: 1, valid: 0, pc: '0, instr: '0, hlt: 0, halted: 0, haddr: '0};
    end else begin
      m_cur.rst = 0;
      if (m_halted) begin
        if (!stall) m_cur.valid = 0;
      end else if (branch_taken) begin
        m_next      = branch_target;
        m_skip      = 1;
        m_cur.valid = 0;
      end else if (!stall) begin
        if (m_skip > 0) begin
          m_skip--;
          m_cur.valid = 0;
        end else begin
          m_cur.valid = 1;
          m_cur.pc    = m_next;
          m_cur.instr = mem(m_next);
          m_next      = m_next + 1'b1;
          if (m_cur.instr[31:27] == 5'b11111) begin
            m_halted     = 1;
            m_cur.hlt    = 1;
            m_cur.halted = 1;
            m_cur.haddr  = m_next;
          end
        end
      end
    end
    q.push_back(m_cur);
  end

  // Monitor: compare the DUT against the oldest expectation each falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ID_valid", {63'b0, ID_valid}, {63'b0, e.valid});
      chk("hlt", {63'b0, hlt}, {63'b0, e.hlt});
      if (e.rst) begin
        chk("rst_ID_PC", {42'b0, ID_PC}, 64'd0);
        chk("rst_ID_instr", {32'b0, ID_instr}, 64'd0);
        chk("rst_ID_PC_out", {42'b0, ID_PC_out}, 64'd1);
      end
      if (e.valid) begin
        logic [PC_W-1:0] nxt;
        nxt = e.pc + 1'b1;
        chk("ID_PC", {42'b0, ID_PC}, {42'b0, e.pc});
        chk("ID_instr", {32'b0, ID_instr}, {32'b0, e.instr});
        chk("ID_PC_out", {42'b0, ID_PC_out}, {42'b0, nxt});
      end
      if (e.halted) chk("halt_instr_addr", {42'b0, instr_addr}, {42'b0, e.haddr});
    end
  end

  // One clock of stimulus; inputs change just after the rising edge
  task automatic step(input bit s, input bit b, input logic [PC_W-1:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  // Asynchronous reset applied mid-cycle, held for two edges
  task automatic do_reset();
    @(negedge clk);
    #1;
    stall        = 0;
    branch_taken = 0;
    rst_n        = 0;
    #1;
    chk("async_rst_valid", {63'b0, ID_valid}, 64'd0);
    chk("async_rst_hlt", {63'b0, hlt}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;

    // Straight-line fetch, a 3-cycle stall, branch under stall
    run(7);
    for (int i = 0; i < 3; i++) step(1, 0, '0);
    run(4);
    step(1, 1, 22'h100);
    step(1, 0, '0);
    run(6);

    // HLT at address 3; later branches and stalls must not disturb the halt
    hlt_at[22'd3] = 1;
    do_reset();
    run(8);
    step(0, 1, 22'h40);
    step(1, 1, 22'h50);
    step(1, 0, '0);
    run(3);

    // Branch on the edge a HLT would enter ID, then wrap at the top of PC
    hlt_at.delete();
    hlt_at[22'h203] = 1;
    do_reset();
    run(3);
    step(0, 1, 22'h200);
    run(4);
    step(0, 1, 22'h3FFFFE);
    run(8);

    // Randomized traffic with occasional HLTs and wrap-adjacent targets
    for (int ph = 0; ph < 4; ph++) begin
      hlt_at.delete();
      hlt_at[22'($urandom_range(16, 127))] = 1;
      do_reset();
      for (int i = 0; i < 250; i++) begin
        int r;
        logic [PC_W-1:0] t;
        r = $urandom_range(0, 99);
        if ($urandom_range(0, 3) == 0) t = 22'h3FFFFC + 22'($urandom_range(0, 3));
        else                           t = 22'($urandom_range(0, 127));
        step(r < 25, r >= 90, t);
      end
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
